// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 lines, deframes
// 11-bit frames and emits one enable strobe per key press (break and E0 prefixes dropped).
module ps2_scancode_rx #(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT      = 50000,
  parameter int IGNORE_BREAK = 1
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       enable,
  output logic       frame_err
);

  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             filt_clk_q, filt_clk_d;
  logic [7:0]       filt_cnt_q, filt_cnt_d;
  logic             filt_fall_q, filt_fall_d;
  state_t           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             break_pend_q, break_pend_d;
  logic [7:0]       scancode_q, scancode_d;
  logic             enable_q, enable_d;
  logic             frame_err_q, frame_err_d;
  logic             byte_done, frame_bad;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_clk_q   <= 1'b1;
      filt_cnt_q   <= '0;
      filt_fall_q  <= 1'b0;
      state_q      <= S_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      timer_q      <= '0;
      break_pend_q <= 1'b0;
      scancode_q   <= '0;
      enable_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      filt_clk_q   <= filt_clk_d;
      filt_cnt_q   <= filt_cnt_d;
      filt_fall_q  <= filt_fall_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      timer_q      <= timer_d;
      break_pend_q <= break_pend_d;
      scancode_q   <= scancode_d;
      enable_q     <= enable_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // The level only flips after the disagreeing count has already reached FILTER_LEN,
  // so a clean edge shows up FILTER_LEN+2 cycles after the raw input moves.
  always_comb begin
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = '0;
    filt_fall_d = 1'b0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == 8'(FILTER_LEN)) begin
        filt_clk_d  = ~filt_clk_q;
        filt_fall_d = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    timer_d   = (state_q == S_IDLE || filt_fall_d) ? '0 : timer_q + TMR_W'(1);
    if (state_q != S_IDLE && !filt_fall_q && timer_q == TMR_W'(TIMEOUT - 1)) begin
      state_d   = S_IDLE;
      frame_bad = 1'b1;
    end else if (filt_fall_q) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if ((^shift_q ^ par_q) && dat_s2_q) byte_done = 1'b1;
          else                                frame_bad = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    scancode_d   = scancode_q;
    enable_d     = 1'b0;
    frame_err_d  = frame_bad;
    break_pend_d = break_pend_q;
    if (frame_bad) begin
      break_pend_d = 1'b0;
    end else if (byte_done) begin
      if (shift_q == 8'hF0) begin
        break_pend_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        break_pend_d = break_pend_q;
      end else if (break_pend_q && IGNORE_BREAK != 0) begin
        break_pend_d = 1'b0;
      end else begin
        scancode_d   = shift_q;
        enable_d     = 1'b1;
        break_pend_d = 1'b0;
      end
    end
  end

  assign scancode  = scancode_q;
  assign enable    = enable_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: directed and random PS/2 frames checked every cycle
// against a frame-level model of when enable/frame_err must fire and what scancode holds.
module tb_ps2_scancode_rx;

  localparam int FL = 8;
  localparam int TO = 2500;
  localparam int IB = 1;

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scancode;
  logic       enable;
  logic       frame_err;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .IGNORE_BREAK(IB)) dut (
    .clk25(clk25),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .scancode(scancode),
    .enable(enable),
    .frame_err(frame_err)
  );

  always #20 clk25 = ~clk25;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         en_cnt = 0;
  int         err_cnt = 0;
  int         last_en_cyc = -1;
  int         last_err_cyc = -1;
  int         exp_en_q[$];
  logic [7:0] exp_code_q[$];
  int         exp_err_q[$];
  logic [7:0] model_code = 8'h00;
  bit         model_bp = 1'b0;
  bit         run_chk = 1'b0;
  bit         ee, er;
  logic [7:0] code_tmp;
  int         cyc_tmp;

  always @(posedge clk25) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Frame-level rules: a stop-bit fall seen at cycle c produces its strobe at c+FL+4.
  task automatic model_frame(input logic [7:0] b, input bit good, input int stop_cyc);
    int t;
    t = stop_cyc + FL + 4;
    if (!good) begin
      exp_err_q.push_back(t);
      model_bp = 1'b0;
    end else if (b == 8'hF0) begin
      model_bp = 1'b1;
    end else if (b == 8'hE0) begin
      model_bp = model_bp;
    end else if (model_bp && IB != 0) begin
      model_bp = 1'b0;
    end else begin
      exp_en_q.push_back(t);
      exp_code_q.push_back(b);
      model_bp = 1'b0;
    end
  endtask

  always @(negedge clk25) begin
    if (run_chk) begin
      while (exp_en_q.size() > 0 && exp_en_q[0] < cyc) begin
        cyc_tmp  = exp_en_q.pop_front();
        code_tmp = exp_code_q.pop_front();
      end
      while (exp_err_q.size() > 0 && exp_err_q[0] < cyc) cyc_tmp = exp_err_q.pop_front();
      ee = exp_en_q.size() > 0 && exp_en_q[0] == cyc;
      er = exp_err_q.size() > 0 && exp_err_q[0] == cyc;
      if (ee) begin
        cyc_tmp    = exp_en_q.pop_front();
        model_code = exp_code_q.pop_front();
      end
      if (er) cyc_tmp = exp_err_q.pop_front();
      if (reset) model_code = 8'h00;
      check("enable", enable, ee);
      check("frame_err", frame_err, er);
      check("scancode", scancode, model_code);
      if (enable)    begin en_cnt++;  last_en_cyc  = cyc; end
      if (frame_err) begin err_cnt++; last_err_cyc = cyc; end
    end
  end

  // Sends the first nbits of a frame; glitch_bit >= 0 adds a 3-cycle low pulse in that bit's high phase.
  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_v,
                            input int nbits, input int half, input int glitch_bit,
                            output int last_fall);
    logic [10:0] f;
    f = {stop_v, (~^b) ^ flip_par, b, 1'b0};
    last_fall = cyc;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk25);
      ps2_data = f[i];
      if (i == glitch_bit) begin
        repeat (half / 2) @(negedge clk25);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk25);
        ps2_clk = 1'b1;
        repeat (half - half / 2 - 3) @(negedge clk25);
      end else begin
        repeat (half) @(negedge clk25);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      if (i == 10) model_frame(b, !flip_par && stop_v, cyc);
      repeat (half) @(negedge clk25);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * half + 20) @(negedge clk25);
  endtask

  int         lf, en0, er0;
  logic [7:0] rb;

  initial begin
    repeat (5) @(negedge clk25);
    check("reset_scancode", scancode, 8'h00);
    check("reset_enable", enable, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    reset   = 1'b0;
    run_chk = 1'b1;
    repeat (20) @(negedge clk25);

    // Slow valid frame 0x1C
    en0 = en_cnt; er0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1000, -1, lf);
    check("lat_1C", last_en_cyc - (lf + 1), 11);
    check("pulses_1C", en_cnt - en0, 1);
    check("code_1C", scancode, 8'h1C);
    check("err_1C", err_cnt - er0, 0);

    // Make, break, make-of-same-key
    en0 = en_cnt;
    send_frame(8'h2D, 1'b0, 1'b1, 11, 20, -1, lf);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 20, -1, lf);
    send_frame(8'h2D, 1'b0, 1'b1, 11, 20, -1, lf);
    check("pulses_2D", en_cnt - en0, 1);
    check("code_2D", scancode, 8'h2D);

    // Extended prefix
    en0 = en_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, 11, 20, -1, lf);
    check("pulses_E0", en_cnt - en0, 0);
    send_frame(8'h75, 1'b0, 1'b1, 11, 20, -1, lf);
    check("code_75", scancode, 8'h75);
    send_frame(8'h76, 1'b0, 1'b1, 11, 20, -1, lf);
    check("pulses_E0_75_76", en_cnt - en0, 2);
    check("code_76", scancode, 8'h76);

    // Parity error then recovery
    en0 = en_cnt; er0 = err_cnt;
    send_frame(8'h16, 1'b1, 1'b1, 11, 20, -1, lf);
    check("perr_errs", err_cnt - er0, 1);
    check("perr_pulses", en_cnt - en0, 0);
    check("perr_code", scancode, 8'h76);
    send_frame(8'h1E, 1'b0, 1'b1, 11, 20, -1, lf);
    check("code_1E", scancode, 8'h1E);

    // Timeout after start + 5 data bits: filtered fall at lf+FL+3, error TO cycles later
    er0 = err_cnt;
    send_frame(8'h26, 1'b0, 1'b1, 6, 20, -1, lf);
    exp_err_q.push_back(lf + FL + 3 + TO);
    model_bp = 1'b0;
    repeat (TO + 100) @(negedge clk25);
    check("tmo_errs", err_cnt - er0, 1);
    check("tmo_delay", last_err_cyc - lf, 2511);
    send_frame(8'h26, 1'b0, 1'b1, 11, 20, -1, lf);
    check("code_26", scancode, 8'h26);

    // Glitches in idle (with data low) and mid-frame
    @(negedge clk25);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge clk25);
    ps2_clk  = 1'b1;
    repeat (5) @(negedge clk25);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk25);
    send_frame(8'h4D, 1'b0, 1'b1, 11, 40, 4, lf);
    check("code_4D_glitch", scancode, 8'h4D);

    // Reset after the 4th data bit
    send_frame(8'h5A, 1'b0, 1'b1, 5, 20, -1, lf);
    @(posedge clk25);
    #2 reset = 1'b1;
    #1;
    check("midreset_scancode", scancode, 8'h00);
    check("midreset_enable", enable, 1'b0);
    check("midreset_frame_err", frame_err, 1'b0);
    model_bp = 1'b0;
    repeat (3) @(negedge clk25);
    reset = 1'b0;
    repeat (20) @(negedge clk25);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 20, -1, lf);
    check("code_5A_after_reset", scancode, 8'h5A);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rb = 8'hF0;
      else if ($urandom_range(0, 7) == 0) rb = 8'hE0;
      send_frame(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0, 11,
                 $urandom_range(14, 30), -1, lf);
    end

    repeat (100) @(negedge clk25);
    check("pending_enable", exp_en_q.size(), 0);
    check("pending_frame_err", exp_err_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
